// File: rtl/morse_tx_keyer.sv
// Morse keyer: sends one character (up to 5 dot/dash elements) or a word space per request.
// Optional square-wave sidetone on tone_out when MORSE_TX_TONE_EN is defined.
module morse_tx_keyer #(
    parameter int unsigned CLK_FREQ = 100_000,
    parameter int unsigned UNIT_MS  = 100,
    parameter int unsigned TONE_HZ  = 1_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic [2:0] sym_len,
    input  logic [4:0] sym_bits,
    input  logic       sym_space,
    output logic       key_out,
    output logic       busy,
    output logic       tone_out
);

    localparam int unsigned UNIT_TICKS = CLK_FREQ * UNIT_MS / 1000;
    localparam int unsigned TICK_W     = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_TICKS - 1);

    typedef enum logic [2:0] {
        StIdle, StMark, StElemGap, StCharGap, StWordGap
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        units_q, units_d;   // remaining whole units in this period, minus one
    logic [4:0]        bits_q, bits_d;
    logic [2:0]        left_q, left_d;     // elements still to send, including current
    logic              key_q;
    logic              unit_end, period_end;

    assign unit_end   = (tick_q == TICK_LAST);
    assign period_end = unit_end && (units_q == 2'd0);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        units_d = units_q;
        bits_d  = bits_q;
        left_d  = left_q;

        if (state_q != StIdle) begin
            tick_d = unit_end ? '0 : tick_q + 1'b1;
            if (unit_end && units_q != 2'd0) units_d = units_q - 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (sym_valid) begin
                    tick_d = '0;
                    if (sym_space) begin
                        state_d = StWordGap;
                        units_d = 2'd3;
                    end else if (sym_len != 3'd0) begin
                        state_d = StMark;
                        bits_d  = sym_bits;
                        left_d  = (sym_len > 3'd5) ? 3'd5 : sym_len;
                        units_d = sym_bits[0] ? 2'd2 : 2'd0;
                    end
                end
            end
            StMark: begin
                if (period_end) begin
                    if (left_q == 3'd1) begin
                        state_d = StCharGap;
                        units_d = 2'd2;
                    end else begin
                        state_d = StElemGap;
                        units_d = 2'd0;
                        bits_d  = bits_q >> 1;
                        left_d  = left_q - 3'd1;
                    end
                end
            end
            StElemGap: begin
                if (period_end) begin
                    state_d = StMark;
                    units_d = bits_q[0] ? 2'd2 : 2'd0;
                end
            end
            StCharGap, StWordGap: begin
                if (period_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            units_q <= 2'd0;
            bits_q  <= 5'd0;
            left_q  <= 3'd0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            units_q <= units_d;
            bits_q  <= bits_d;
            left_q  <= left_d;
            key_q   <= (state_d == StMark);
        end
    end

    assign sym_ready = (state_q == StIdle);
    assign busy      = ~sym_ready;
    assign key_out   = key_q;

`ifdef MORSE_TX_TONE_EN
    localparam int unsigned HALF_RAW = CLK_FREQ / (2 * TONE_HZ);
    localparam int unsigned HALF     = (HALF_RAW > 0) ? HALF_RAW : 1;
    localparam int unsigned TONE_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [TONE_W-1:0] HALF_LAST = TONE_W'(HALF - 1);

    logic [TONE_W-1:0] tone_cnt_q;
    logic              tone_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (!key_q) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (tone_cnt_q == HALF_LAST) begin
            tone_cnt_q <= '0;
            tone_q     <= ~tone_q;
        end else begin
            tone_cnt_q <= tone_cnt_q + 1'b1;
        end
    end

    assign tone_out = tone_q & key_q;
`else
    assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_tx_keyer.sv
// Self-checking bench for morse_tx_keyer (CLK_FREQ=1000, UNIT_MS=10 -> 10-cycle unit).
// Per-cycle compare against a waveform model derived from Morse timing rules.
module tb_morse_tx_keyer;

    localparam int U = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [2:0] sym_len = 3'd0;
    logic [4:0] sym_bits = 5'd0;
    logic       sym_space = 1'b0;
    logic       key_out;
    logic       busy;
    logic       tone_out;

    int checks = 0;
    int errors = 0;

    morse_tx_keyer #(
        .CLK_FREQ(1000),
        .UNIT_MS (10),
        .TONE_HZ (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sym_len  (sym_len),
        .sym_bits (sym_bits),
        .sym_space(sym_space),
        .key_out  (key_out),
        .busy     (busy),
        .tone_out (tone_out)
    );

    always #5 clk = ~clk;

    // Waveform of one request as a function of cycle index since the mark started.
    function automatic int wave_len(input int len, input logic [4:0] bits, input bit space);
        int l;
        int t;
        if (space) return 4 * U;
        l = (len > 5) ? 5 : len;
        t = 0;
        for (int i = 0; i < l; i++) begin
            t += bits[i] ? 3 * U : U;
            t += (i == l - 1) ? 3 * U : U;
        end
        return t;
    endfunction

    function automatic bit wave_at(input int len, input logic [4:0] bits, input bit space,
                                   input int k);
        int l;
        int t;
        int m;
        int g;
        if (space) return 1'b0;
        l = (len > 5) ? 5 : len;
        t = k;
        for (int i = 0; i < l; i++) begin
            m = bits[i] ? 3 * U : U;
            if (t < m) return 1'b1;
            t -= m;
            g = (i == l - 1) ? 3 * U : U;
            if (t < g) return 1'b0;
            t -= g;
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model state
    bit         m_active = 1'b0;
    int         m_len = 0;
    logic [4:0] m_bits = 5'd0;
    bit         m_space = 1'b0;
    int         m_idx = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_idx    <= 0;
        end else if (m_active) begin
            if (m_idx + 1 >= wave_len(m_len, m_bits, m_space)) m_active <= 1'b0;
            m_idx <= m_idx + 1;
        end else if (sym_valid) begin
            m_len    <= int'(sym_len);
            m_bits   <= sym_bits;
            m_space  <= sym_space;
            m_idx    <= 0;
            m_active <= (wave_len(int'(sym_len), sym_bits, sym_space) > 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_key", int'(key_out),
                  m_active ? int'(wave_at(m_len, m_bits, m_space, m_idx)) : 0);
            check("cyc_ready", int'(sym_ready), m_active ? 0 : 1);
            check("cyc_busy", int'(busy), m_active ? 1 : 0);
`ifndef MORSE_TX_TONE_EN
            check("cyc_tone", int'(tone_out), 0);
`endif
        end
    end

    task automatic send(input logic [2:0] len, input logic [4:0] bits, input logic space);
        int n;
        n = 0;
        while (!sym_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("send_wait_ready", int'(sym_ready), 1);
        sym_len   = len;
        sym_bits  = bits;
        sym_space = space;
        sym_valid = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0;
        sym_len   = 3'($urandom);
        sym_bits  = 5'($urandom);
        sym_space = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!sym_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        // Reset state
        #1;
        check("rst_key", int'(key_out), 0);
        check("rst_ready", int'(sym_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_tone", int'(tone_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // Model pins
        check("pin_len_E", wave_len(1, 5'b00000, 1'b0), 40);
        check("pin_len_A", wave_len(2, 5'b00010, 1'b0), 80);
        check("pin_len_space", wave_len(0, 5'b00000, 1'b1), 40);
        check("pin_len_7", wave_len(7, 5'b11111, 1'b0), 220);
        check("pin_len_0", wave_len(0, 5'b11111, 1'b0), 0);
        check("pin_A_10", int'(wave_at(2, 5'b00010, 1'b0, 10)), 0);
        check("pin_A_20", int'(wave_at(2, 5'b00010, 1'b0, 20)), 1);
        check("pin_A_49", int'(wave_at(2, 5'b00010, 1'b0, 49)), 1);
        check("pin_A_50", int'(wave_at(2, 5'b00010, 1'b0, 50)), 0);

        // 'E'
        send(3'd1, 5'b00000, 1'b0);
        check("E_first_key", int'(key_out), 1);
        wait_idle(n);
        check("E_ready_after", n, 40);

        // 'A'
        send(3'd2, 5'b00010, 1'b0);
        wait_idle(n);
        check("A_ready_after", n, 80);

        // Word space then 'T'
        send(3'd0, 5'b00000, 1'b1);
        check("space_key", int'(key_out), 0);
        wait_idle(n);
        check("space_ready_after", n, 40);
        send(3'd1, 5'b00001, 1'b0);
        wait_idle(n);
        check("T_ready_after", n, 60);

        // Request while busy is ignored
        send(3'd2, 5'b00010, 1'b0);
        repeat (4) @(negedge clk);
        sym_len   = 3'd1;
        sym_bits  = 5'b00001;
        sym_valid = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0;
        wait_idle(n);
        check("busy_ignore_total", n + 5, 80);

        // len=0 no-op
        send(3'd0, 5'b10101, 1'b0);
        check("len0_ready", int'(sym_ready), 1);
        check("len0_key", int'(key_out), 0);

        // len=7 clamps to 5 dashes
        send(3'd7, 5'b11111, 1'b0);
        wait_idle(n);
        check("len7_ready_after", n, 220);

        // Reset mid-dash
        send(3'd1, 5'b00001, 1'b0);
        repeat (14) @(negedge clk);
        check("dash_mid_key", int'(key_out), 1);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_key", int'(key_out), 0);
        check("midrst_ready", int'(sym_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_tone", int'(tone_out), 0);
        @(negedge clk);
        rst = 1'b0;
        send(3'd1, 5'b00000, 1'b0);
        check("post_rst_key", int'(key_out), 1);
        wait_idle(n);
        check("post_rst_ready_after", n, 40);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
